// File: rtl/alarm_pkg.sv
// Shared types and width helpers for the alarm ringer.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } ring_state_t;

    localparam int DEF_CLK_HZ     = 100_000_000;
    localparam int DEF_TONE_HZ    = 2000;
    localparam int DEF_BEEP_HZ    = 2;
    localparam int DEF_RING_SEC   = 60;
    localparam int DEF_SNOOZE_SEC = 300;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int sec_w(input int ring_sec, input int snooze_sec);
        return cnt_w((ring_sec > snooze_sec) ? ring_sec : snooze_sec);
    endfunction

endpackage

// File: rtl/alarm_tick_gen.sv
// Divide-by-N pulse generator: tick is high on the Nth enabled cycle after clear.
module alarm_tick_gen
    import alarm_pkg::*;
#(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = cnt_w(N);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == W'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alarm_ringer.sv
// Alarm buzzer controller: bing edge -> gated tone for RING_SEC seconds, stop/snooze buttons.
// Optional snooze state is built only when ALARM_SNOOZE_EN is defined.
module alarm_ringer
    import alarm_pkg::*;
#(
    parameter int CLK_HZ     = DEF_CLK_HZ,
    parameter int TONE_HZ    = DEF_TONE_HZ,
    parameter int BEEP_HZ    = DEF_BEEP_HZ,
    parameter int RING_SEC   = DEF_RING_SEC,
    parameter int SNOOZE_SEC = DEF_SNOOZE_SEC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bing,
    input  logic alarm_en,
    input  logic stop_btn,
    input  logic snooze_btn,
    output logic buzzer,
    output logic ringing,
    output logic snoozing
);

    localparam int SEC_W     = sec_w(RING_SEC, SNOOZE_SEC);
    localparam int TONE_HALF = CLK_HZ / (2 * TONE_HZ);
    localparam int BEEP_HALF = CLK_HZ / (2 * BEEP_HZ);

    logic bing_s1, bing_s2, bing_d, bing_rise;
    ring_state_t state, state_n;
    logic ring_entry, timer_clr, timer_run;
    logic sec_tick, sec_done;
    logic [SEC_W-1:0] sec_cnt;
    logic tone_tick, beep_tick;
    logic tone_q, beep_on, tone_nxt, beep_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bing_s1 <= 1'b0;
            bing_s2 <= 1'b0;
            bing_d  <= 1'b0;
        end else begin
            bing_s1 <= bing;
            bing_s2 <= bing_s1;
            bing_d  <= bing_s2;
        end
    end

    assign bing_rise = bing_s2 & ~bing_d;

    always_comb begin
        state_n = state;
        if (!alarm_en) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (bing_rise) state_n = RING;
                // A bing edge while already ringing is deliberately ignored.
                RING: begin
                    if (stop_btn)        state_n = IDLE;
`ifdef ALARM_SNOOZE_EN
                    else if (snooze_btn) state_n = SNOOZE;
`endif
                    else if (sec_done)   state_n = IDLE;
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (stop_btn)       state_n = IDLE;
                    else if (bing_rise) state_n = RING;
                    else if (sec_done)  state_n = RING;
                end
`endif
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    assign ring_entry = (state_n == RING) && (state != RING);

`ifdef ALARM_SNOOZE_EN
    assign timer_clr = ring_entry || ((state_n == SNOOZE) && (state != SNOOZE));
    assign timer_run = (state == RING) || (state == SNOOZE);
    assign sec_done  = sec_tick &&
                       (sec_cnt == ((state == SNOOZE) ? SEC_W'(SNOOZE_SEC - 1) : SEC_W'(RING_SEC - 1)));
    assign snoozing  = (state == SNOOZE);
`else
    logic unused_snooze_btn;
    assign unused_snooze_btn = snooze_btn;
    assign timer_clr = ring_entry;
    assign timer_run = (state == RING);
    assign sec_done  = sec_tick && (sec_cnt == SEC_W'(RING_SEC - 1));
    assign snoozing  = 1'b0;
`endif

    assign ringing = (state == RING);

    alarm_tick_gen #(.N(CLK_HZ)) u_sec_tick (
        .clk(clk), .rst_n(rst_n), .clr(timer_clr), .en(timer_run), .tick(sec_tick)
    );

    alarm_tick_gen #(.N(TONE_HALF)) u_tone_tick (
        .clk(clk), .rst_n(rst_n), .clr(ring_entry), .en(ringing), .tick(tone_tick)
    );

    alarm_tick_gen #(.N(BEEP_HALF)) u_beep_tick (
        .clk(clk), .rst_n(rst_n), .clr(ring_entry), .en(ringing), .tick(beep_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_cnt <= '0;
        end else if (timer_clr) begin
            sec_cnt <= '0;
        end else if (sec_tick) begin
            sec_cnt <= sec_done ? '0 : sec_cnt + 1'b1;
        end
    end

    // Buzzer is registered from next-cycle values so it stays aligned with ringing.
    assign tone_nxt = ring_entry ? 1'b0 : (tone_tick ? ~tone_q  : tone_q);
    assign beep_nxt = ring_entry ? 1'b1 : (beep_tick ? ~beep_on : beep_on);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_q  <= 1'b0;
            beep_on <= 1'b0;
            buzzer  <= 1'b0;
        end else begin
            tone_q  <= tone_nxt;
            beep_on <= beep_nxt;
            buzzer  <= tone_nxt & beep_nxt & (state_n == RING);
        end
    end

endmodule

// File: tb/tb_alarm_ringer.sv
// Directed self-checking bench for alarm_ringer (1 kHz clock scaling).
module tb_alarm_ringer;

    logic clk = 1'b0;
    logic rst_n, bing, alarm_en, stop_btn, snooze_btn;
    logic buzzer, ringing, snoozing;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alarm_ringer #(
        .CLK_HZ(1000), .TONE_HZ(100), .BEEP_HZ(2), .RING_SEC(3), .SNOOZE_SEC(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bing(bing), .alarm_en(alarm_en),
        .stop_btn(stop_btn), .snooze_btn(snooze_btn),
        .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Tone period 10 cycles (high in second half), beep window 500 cycles (on in first half).
    function automatic logic buz_model(input int k);
        return (((k / 5) % 2) == 1) && (((k / 250) % 2) == 0);
    endfunction

    // Samples k0..k1-1 of a RING, then advances one more edge; optional bing drop/raise.
    task automatic run_ring(input string tag, input int k0, input int k1,
                            input int drop_at, input int raise_at);
        int bad;
        int first;
        bad = 0;
        first = -1;
        for (int k = k0; k < k1; k++) begin
            if (buzzer !== buz_model(k) || ringing !== 1'b1 || snoozing !== 1'b0) begin
                bad++;
                if (first < 0) first = k;
            end
            if (k == drop_at)  bing = 1'b0;
            if (k == raise_at) bing = 1'b1;
            tick();
        end
        if (bad != 0) $display("note %s first bad cycle %0d", tag, first);
        chk({tag, "_pattern"}, bad, 0);
    endtask

    // Raises bing; ringing must appear on the third edge after.
    task automatic start_ring(input string tag);
        bing = 1'b1;
        tick(2);
        chk({tag, "_ring_before_3rd_edge"}, {31'd0, ringing}, 0);
        tick();
        chk({tag, "_ring_at_3rd_edge"}, {31'd0, ringing}, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        bing = 1'b0;
        alarm_en = 1'b0;
        stop_btn = 1'b0;
        snooze_btn = 1'b0;

        tick(3);
        chk("reset_buzzer", {31'd0, buzzer}, 0);
        chk("reset_ringing", {31'd0, ringing}, 0);
        chk("reset_snoozing", {31'd0, snoozing}, 0);
        rst_n = 1'b1;
        alarm_en = 1'b1;
        tick(5);
        chk("idle_ringing", {31'd0, ringing}, 0);

        // Basic ring: exactly 3000 cycles of gated tone
        start_ring("basic");
        run_ring("basic", 0, 3000, 997, -1);
        chk("basic_end_ringing", {31'd0, ringing}, 0);
        chk("basic_end_buzzer", {31'd0, buzzer}, 0);
        tick(20);
        chk("basic_idle_after", {31'd0, ringing}, 0);

        // Stop button while the tone is about to sound
        start_ring("stop");
        run_ring("stop", 0, 1004, 997, -1);
        stop_btn = 1'b1;
        tick();
        stop_btn = 1'b0;
        chk("stop_ringing", {31'd0, ringing}, 0);
        chk("stop_buzzer", {31'd0, buzzer}, 0);
        tick(10);
        chk("stop_stays_idle", {31'd0, ringing}, 0);

        // Disabled alarm: bing edge must not ring
        alarm_en = 1'b0;
        bing = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                if (ringing !== 1'b0 || buzzer !== 1'b0) seen++;
                tick();
            end
            chk("disabled_no_ring", seen, 0);
        end
        bing = 1'b0;
        tick(5);
        alarm_en = 1'b1;
        tick(5);
        chk("disabled_reenable_idle", {31'd0, ringing}, 0);

        // Retrigger during RING: end time stays 3000 cycles after first entry
        start_ring("retrig");
        run_ring("retrig", 0, 3000, 500, 1500);
        chk("retrig_end_ringing", {31'd0, ringing}, 0);
        bing = 1'b0;
        tick(5);

        // Stop and snooze in the same cycle: stop wins
        start_ring("both");
        run_ring("both", 0, 700, 100, -1);
        stop_btn = 1'b1;
        snooze_btn = 1'b1;
        tick();
        stop_btn = 1'b0;
        snooze_btn = 1'b0;
        chk("both_ringing", {31'd0, ringing}, 0);
        chk("both_snoozing", {31'd0, snoozing}, 0);
        tick(5);
        chk("both_snoozing_later", {31'd0, snoozing}, 0);

`ifdef ALARM_SNOOZE_EN
        // Snooze for 2000 cycles, then a fresh 3000-cycle ring
        start_ring("snz");
        run_ring("snz", 0, 500, 100, -1);
        snooze_btn = 1'b1;
        tick();
        snooze_btn = 1'b0;
        chk("snz_enter_snoozing", {31'd0, snoozing}, 1);
        chk("snz_enter_ringing", {31'd0, ringing}, 0);
        begin
            int bad;
            bad = 0;
            for (int s = 0; s < 2000; s++) begin
                if (snoozing !== 1'b1 || ringing !== 1'b0 || buzzer !== 1'b0) bad++;
                tick();
            end
            chk("snz_hold_2000", bad, 0);
        end
        chk("snz_rering_ringing", {31'd0, ringing}, 1);
        chk("snz_rering_snoozing", {31'd0, snoozing}, 0);
        run_ring("snz_rering", 0, 3000, -1, -1);
        chk("snz_rering_end", {31'd0, ringing}, 0);

        // bing edge during SNOOZE rings at once with a fresh timer
        start_ring("snzb");
        run_ring("snzb", 0, 200, 50, -1);
        snooze_btn = 1'b1;
        tick();
        snooze_btn = 1'b0;
        tick(100);
        bing = 1'b1;
        tick(2);
        chk("snzb_still_snoozing", {31'd0, snoozing}, 1);
        tick();
        chk("snzb_ringing", {31'd0, ringing}, 1);
        chk("snzb_snoozing", {31'd0, snoozing}, 0);
        run_ring("snzb_ring", 0, 3000, 10, -1);
        chk("snzb_end", {31'd0, ringing}, 0);
        tick(5);
`else
        // Without snooze support the button is ignored
        start_ring("nosnz");
        run_ring("nosnz", 0, 500, 100, -1);
        snooze_btn = 1'b1;
        tick();
        snooze_btn = 1'b0;
        chk("nosnz_ringing", {31'd0, ringing}, 1);
        chk("nosnz_snoozing", {31'd0, snoozing}, 0);
        run_ring("nosnz_cont", 501, 3000, -1, -1);
        chk("nosnz_end", {31'd0, ringing}, 0);
        tick(5);
`endif

        // Asynchronous reset mid-ring silences outputs before the next edge
        start_ring("rst");
        run_ring("rst", 0, 1205, 500, -1);
        chk("rst_buzzer_before", {31'd0, buzzer}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_buzzer", {31'd0, buzzer}, 0);
        chk("rst_async_ringing", {31'd0, ringing}, 0);
        tick(2);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 30; i++) begin
                if (ringing !== 1'b0 || buzzer !== 1'b0) seen++;
                tick();
            end
            chk("rst_no_ring_after", seen, 0);
        end
        start_ring("rst_new");
        run_ring("rst_new", 0, 300, 100, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
